// File: rtl/loader_pkg.sv
// Shared definitions for the parameter stream loaders: FSM encoding, BRAM geometry
// and the per-layer base addresses the sequencer drives onto base_addr.
package loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_t;

  localparam int BRAM_DW = 8;

  localparam logic [17:0] LAYER1_WEIGHT_BASE = 18'd0;
  localparam logic [17:0] LAYER1_BIAS_BASE   = 18'd147512;

  // Counter/index width that never collapses to zero bits for single-entry cases.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/loader_rd_tracker.sv
// Tags every issued BRAM read through an RD_LAT-deep valid pipe and tracks which
// byte lane of which element the returning data belongs to.
module loader_rd_tracker
  import loader_pkg::*;
#(
  parameter int COUNT  = 8,
  parameter int BPW    = 1,
  parameter int RD_LAT = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          issue,
  output logic                          capture,
  output logic [clog2_min1(BPW)-1:0]    byte_lane,
  output logic [clog2_min1(COUNT)-1:0]  elem_idx,
  output logic                          elem_last,
  output logic                          load_last,
  output logic                          pipe_busy
);

  localparam int BW = clog2_min1(BPW);
  localparam int EW = clog2_min1(COUNT);
  localparam logic [BW-1:0] LAST_LANE = BW'(BPW - 1);
  localparam logic [EW-1:0] LAST_ELEM = EW'(COUNT - 1);

  logic [RD_LAT-1:0] vpipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vpipe <= '0;
    end else if (clear) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
      end
    end
  end

  // Data is only trusted when the tag that left with its read arrives at the tail.
  assign capture   = vpipe[RD_LAT-1];
  assign pipe_busy = |vpipe;
  assign elem_last = (byte_lane == LAST_LANE);
  assign load_last = elem_last && (elem_idx == LAST_ELEM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_lane <= '0;
      elem_idx  <= '0;
    end else if (clear) begin
      byte_lane <= '0;
      elem_idx  <= '0;
    end else if (capture) begin
      if (elem_last) begin
        byte_lane <= '0;
        elem_idx  <= load_last ? '0 : elem_idx + 1'b1;
      end else begin
        byte_lane <= byte_lane + 1'b1;
      end
    end
  end

endmodule

// File: rtl/param_stream_loader.sv
// Generic BRAM-to-register loader: reads COUNT little-endian W-bit elements from the
// shared byte-wide BRAM at a runtime base address and streams each one as it completes.
module param_stream_loader
  import loader_pkg::*;
#(
  parameter int COUNT      = 8,
  parameter int W          = 8,
  parameter int ADDR_WIDTH = 18,
  parameter int RD_LAT     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         base_addr,
  output logic                          busy,
  output logic                          done,
  output logic [COUNT*W-1:0]            data_out,
  output logic                          out_valid,
  output logic [W-1:0]                  out_data,
  output logic [clog2_min1(COUNT)-1:0]  out_index,
  output logic                          bram_en,
  output logic                          bram_ren,
  output logic                          bram_wen,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  input  logic [BRAM_DW-1:0]            bram_dout
);

  localparam int BPW  = W / BRAM_DW;
  localparam int N_RD = COUNT * BPW;
  localparam int KW   = clog2_min1(N_RD);
  localparam int BW   = clog2_min1(BPW);
  localparam int EW   = clog2_min1(COUNT);
  localparam int DIW  = clog2_min1(COUNT * W);
  localparam int LIW  = clog2_min1(W);
  localparam logic [KW-1:0] LAST_RD = KW'(N_RD - 1);

  loader_state_t state, state_next;

  logic [ADDR_WIDTH-1:0] base_q;
  logic [KW-1:0]         rd_cnt;
  logic                  accept;
  logic                  issue;
  logic                  capture;
  logic                  elem_last;
  logic                  load_last;
  logic                  pipe_busy;
  logic [BW-1:0]         byte_lane;
  logic [EW-1:0]         elem_idx;
  logic [DIW-1:0]        byte_lsb;
  logic [DIW-1:0]        elem_lsb;
  logic [LIW-1:0]        lane_lsb;
  logic [W-1:0]          elem_value;

  loader_rd_tracker #(
    .COUNT  (COUNT),
    .BPW    (BPW),
    .RD_LAT (RD_LAT)
  ) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .issue     (issue),
    .capture   (capture),
    .byte_lane (byte_lane),
    .elem_idx  (elem_idx),
    .elem_last (elem_last),
    .load_last (load_last),
    .pipe_busy (pipe_busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The BRAM clock enable stays up in DRAIN only while tagged reads are still in flight.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue      = 1'b0;
    bram_en    = 1'b0;
    bram_ren   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issue    = 1'b1;
        bram_en  = 1'b1;
        bram_ren = 1'b1;
        if (rd_cnt == LAST_RD) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        bram_en = pipe_busy;
        if (capture && load_last) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bram_wen  = 1'b0;
  assign bram_addr = issue ? base_q + ADDR_WIDTH'(rd_cnt) : '0;
  assign busy      = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);

  // The final byte of an element is merged here so out_data appears with the same edge.
  always_comb begin
    elem_lsb   = DIW'(int'(elem_idx) * W);
    lane_lsb   = LIW'(int'(byte_lane) * BRAM_DW);
    byte_lsb   = DIW'(int'(elem_idx) * W + int'(byte_lane) * BRAM_DW);
    elem_value = data_out[elem_lsb +: W];
    elem_value[lane_lsb +: BRAM_DW] = bram_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q    <= '0;
      rd_cnt    <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        base_q   <= base_addr;
        rd_cnt   <= '0;
        data_out <= '0;
      end else if (issue) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
      if (capture) begin
        data_out[byte_lsb +: BRAM_DW] <= bram_dout;
        if (elem_last) begin
          out_valid <= 1'b1;
          out_data  <= elem_value;
          out_index <= elem_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_param_stream_loader.sv
// Scoreboard bench for param_stream_loader: four instances with different geometry and
// read latency share one behavioural BRAM; monitors check every read address and element.
module tb_param_stream_loader;
  import loader_pkg::*;

  localparam int AW = 18;
  localparam int CNT_P [4] = '{8, 4, 4, 1};
  localparam int W_P   [4] = '{8, 16, 16, 16};
  localparam int LAT_P [4] = '{2, 2, 3, 1};

  typedef struct {
    int          dut;
    int          idx;
    logic [15:0] data;
  } elem_t;

  typedef struct {
    int          dut;
    logic [AW-1:0] a;
  } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0]         start;
  logic [3:0][AW-1:0] base;

  wire [3:0]          busy, done, ov, en, ren, wen;
  wire [3:0][AW-1:0]  addr;
  wire [3:0][7:0]     bdout;
  wire [63:0]         do_a, do_b, do_c;
  wire [15:0]         do_d;
  wire [7:0]          od_a;
  wire [15:0]         od_b, od_c, od_d;
  wire [2:0]          oi_a;
  wire [1:0]          oi_b, oi_c;
  wire [0:0]          oi_d;
  wire [3:0][15:0]    od_all;
  wire [3:0][2:0]     oi_all;

  logic [7:0] mem [0:(1<<AW)-1];

  elem_t elem_q[$];
  rd_t   rd_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  assign od_all = {od_d, od_c, od_b, {8'h00, od_a}};
  assign oi_all = {{2'b00, oi_d}, {1'b0, oi_c}, {1'b0, oi_b}, oi_a};

  param_stream_loader #(.COUNT(8), .W(8), .ADDR_WIDTH(AW), .RD_LAT(2)) u_a (
    .clk(clk), .rst(rst), .start(start[0]), .base_addr(base[0]), .busy(busy[0]), .done(done[0]),
    .data_out(do_a), .out_valid(ov[0]), .out_data(od_a), .out_index(oi_a), .bram_en(en[0]),
    .bram_ren(ren[0]), .bram_wen(wen[0]), .bram_addr(addr[0]), .bram_dout(bdout[0]));

  param_stream_loader #(.COUNT(4), .W(16), .ADDR_WIDTH(AW), .RD_LAT(2)) u_b (
    .clk(clk), .rst(rst), .start(start[1]), .base_addr(base[1]), .busy(busy[1]), .done(done[1]),
    .data_out(do_b), .out_valid(ov[1]), .out_data(od_b), .out_index(oi_b), .bram_en(en[1]),
    .bram_ren(ren[1]), .bram_wen(wen[1]), .bram_addr(addr[1]), .bram_dout(bdout[1]));

  param_stream_loader #(.COUNT(4), .W(16), .ADDR_WIDTH(AW), .RD_LAT(3)) u_c (
    .clk(clk), .rst(rst), .start(start[2]), .base_addr(base[2]), .busy(busy[2]), .done(done[2]),
    .data_out(do_c), .out_valid(ov[2]), .out_data(od_c), .out_index(oi_c), .bram_en(en[2]),
    .bram_ren(ren[2]), .bram_wen(wen[2]), .bram_addr(addr[2]), .bram_dout(bdout[2]));

  param_stream_loader #(.COUNT(1), .W(16), .ADDR_WIDTH(AW), .RD_LAT(1)) u_d (
    .clk(clk), .rst(rst), .start(start[3]), .base_addr(base[3]), .busy(busy[3]), .done(done[3]),
    .data_out(do_d), .out_valid(ov[3]), .out_data(od_d), .out_index(oi_d), .bram_en(en[3]),
    .bram_ren(ren[3]), .bram_wen(wen[3]), .bram_addr(addr[3]), .bram_dout(bdout[3]));

  // Behavioural BRAM read port per instance: RD_LAT register stages behind the address.
  for (genvar g = 0; g < 4; g++) begin : g_bram
    logic [7:0] p0, p1, p2;
    always @(posedge clk) begin
      if (en[g]) begin
        if (ren[g]) p0 <= mem[addr[g]];
        p1 <= p0;
        p2 <= p1;
      end
    end
    assign bdout[g] = (LAT_P[g] == 1) ? p0 : (LAT_P[g] == 2) ? p1 : p2;
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sel_do(input int g);
    case (g)
      0:       return do_a;
      1:       return do_b;
      2:       return do_c;
      default: return {48'h0, do_d};
    endcase
  endfunction

  always @(negedge clk) begin
    elem_t e;
    rd_t   r;
    for (int g = 0; g < 4; g++) begin
      if (ov[g] === 1'b1) begin
        if (elem_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_element dut=%0d actual=%h required=none", g, od_all[g]);
        end else begin
          e = elem_q.pop_front();
          check_output($sformatf("element_dut%0d_idx%0d", e.dut, e.idx),
                       {16'(g), 16'(oi_all[g]), 16'h0, od_all[g]},
                       {16'(e.dut), 16'(e.idx), 16'h0, e.data});
        end
      end
      if (ren[g] === 1'b1) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_read dut=%0d actual=%h required=none", g, addr[g]);
        end else begin
          r = rd_q.pop_front();
          check_output($sformatf("read_addr_dut%0d", r.dut), {16'(g), 14'h0, addr[g]},
                       {16'(r.dut), 14'h0, r.a});
        end
      end
    end
  end

  task automatic push_expect(input int g, input logic [AW-1:0] b, input logic [63:0] exp_do);
    int n_rd;
    logic [15:0] v;
    n_rd = CNT_P[g] * W_P[g] / 8;
    for (int k = 0; k < n_rd; k++) begin
      rd_q.push_back('{g, b + AW'(k)});
    end
    for (int e = 0; e < CNT_P[g]; e++) begin
      v = 16'((exp_do >> (e * W_P[g])) & ((64'd1 << W_P[g]) - 64'd1));
      elem_q.push_back('{g, e, v});
    end
  endtask

  task automatic wait_done(input int g, input int exp_edge, input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (done[g] !== 1'b1 && n < 60);
    check_output({name, "_done_edge"}, 64'(n), 64'(exp_edge));
    check_output({name, "_busy_at_done"}, 64'(busy[g]), 64'd0);
  endtask

  task automatic apply_stimulus(input int g, input logic [AW-1:0] b, input int exp_edge,
                                input logic [63:0] exp_do, input string name);
    push_expect(g, b, exp_do);
    @(negedge clk);
    base[g]  = b;
    start[g] = 1'b1;
    @(posedge clk);
    #1;
    start[g] = 1'b0;
    check_output({name, "_busy_after_start"}, 64'(busy[g]), 64'd1);
    check_output({name, "_done_after_start"}, 64'(done[g]), 64'd0);
    wait_done(g, exp_edge, name);
    @(negedge clk);
    #1;
    check_output({name, "_data_out"}, sel_do(g), exp_do);
    check_output({name, "_pending"}, 64'(elem_q.size() + rd_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    start = '0;
    base  = '0;
    for (int i = 0; i < 8; i++) begin
      mem[int'(LAYER1_BIAS_BASE) + i] = 8'(i + 1);
      mem[1000 + i] = 8'(8'h11 * (i + 1));
      mem[2000 + i] = 8'(8'hA0 + i);
      mem[3000 + i] = 8'(8'h30 + i);
    end
    mem[18'h3FFFF] = 8'hCD;
    mem[0]         = 8'hAB;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      check_output($sformatf("reset_flags_dut%0d", g),
                   {60'h0, busy[g], done[g], ov[g], en[g] | ren[g] | wen[g]}, 64'h0);
      check_output($sformatf("reset_data_dut%0d", g), sel_do(g), 64'h0);
    end
    rst = 1'b0;

    apply_stimulus(0, LAYER1_BIAS_BASE, 10, 64'h0807060504030201, "w8_basic");
    apply_stimulus(1, 18'd1000, 10, 64'h8877665544332211, "w16_lat2");
    apply_stimulus(2, 18'd1000, 11, 64'h8877665544332211, "w16_lat3");
    apply_stimulus(3, 18'h3FFFF, 3, 64'h000000000000ABCD, "wrap");

    // Reset in the middle of ISSUE after three reads have gone out.
    for (int k = 0; k < 3; k++) rd_q.push_back('{0, LAYER1_BIAS_BASE + AW'(k)});
    @(negedge clk);
    base[0]  = LAYER1_BIAS_BASE;
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_output("midreset_flags", {60'h0, busy[0], done[0], ov[0], en[0] | ren[0]}, 64'h0);
    check_output("midreset_data", do_a, 64'h0);
    check_output("midreset_reads_seen", 64'(rd_q.size()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(0, 18'd2000, 10, 64'hA7A6A5A4A3A2A1A0, "after_reset");

    // start held through the whole load, then a new base while still in DONE.
    push_expect(0, LAYER1_BIAS_BASE, 64'h0807060504030201);
    push_expect(0, 18'd3000, 64'h3736353433323130);
    @(negedge clk);
    base[0]  = LAYER1_BIAS_BASE;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    wait_done(0, 10, "hold_first");
    check_output("hold_first_data_out", do_a, 64'h0807060504030201);
    base[0] = 18'd3000;
    @(posedge clk);
    #1;
    check_output("hold_restart_flags", {62'h0, busy[0], done[0]}, 64'h2);
    check_output("hold_restart_cleared", do_a, 64'h0);
    wait_done(0, 10, "hold_second");
    start[0] = 1'b0;
    @(negedge clk);
    #1;
    check_output("hold_second_data_out", do_a, 64'h3736353433323130);
    check_output("hold_pending", 64'(elem_q.size() + rd_q.size()), 64'd0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
